// File: rtl/mlp_pkg.sv
// Shared types and sizing helpers for the MLP layer sequencer.
package mlp_pkg;

    localparam int BITS = 32;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        HOLD,
        DONE
    } seq_state_t;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mlp_valid_delay.sv
// Delays the FEED flag by LAT cycles so acc_en lines up with operands at the MAC input.
module mlp_valid_delay #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic vin,
    output logic vout
);

    logic [LAT:1] vld_pipe;

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_pipe <= '0;
        end else begin
            for (int i = LAT; i > 1; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            vld_pipe[1] <= vin;
        end
    end

    assign vout = vld_pipe[LAT];

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Walks operand indices per neuron, strobes the accumulator and hands off results.
module mlp_layer_sequencer
    import mlp_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int NEURONS = 4,
    parameter int LAT     = 1,
    parameter int NW      = idx_w(NEURONS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [BITS-1:0] idx,
    output logic [NW-1:0]   neuron,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            busy,
    output logic            done
);

    localparam int IW = idx_w(WIDTH + 1);
    localparam int DW = idx_w(LAT);

    seq_state_t     state, state_nxt;
    logic [IW-1:0]  idx_q, idx_nxt;
    logic [NW-1:0]  nrn_q, nrn_nxt;
    logic [DW-1:0]  dcnt_q, dcnt_nxt;
    logic           feed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx_q  <= '0;
            nrn_q  <= '0;
            dcnt_q <= '0;
        end else begin
            state  <= state_nxt;
            idx_q  <= idx_nxt;
            nrn_q  <= nrn_nxt;
            dcnt_q <= dcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_q;
        nrn_nxt   = nrn_q;
        dcnt_nxt  = dcnt_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FEED;
                    idx_nxt   = '0;
                    nrn_nxt   = '0;
                end
            end
            FEED: begin
                if (idx_q == IW'(WIDTH)) begin
                    state_nxt = DRAIN;
                    idx_nxt   = '0;
                    dcnt_nxt  = DW'(LAT - 1);
                end else begin
                    idx_nxt = idx_q + IW'(1);
                end
            end
            DRAIN: begin
                // Wait out the operand-path latency so the last MAC lands.
                if (dcnt_q == '0) begin
                    state_nxt = HOLD;
                end else begin
                    dcnt_nxt = dcnt_q - DW'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    if (nrn_q == NW'(NEURONS - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FEED;
                        nrn_nxt   = nrn_q + NW'(1);
                        idx_nxt   = '0;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                nrn_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                nrn_nxt   = '0;
            end
        endcase
    end

    assign feed      = (state == FEED);
    assign idx       = BITS'(idx_q);
    assign neuron    = nrn_q;
    // idx is only zero on the first FEED cycle of each neuron.
    assign acc_clr   = feed && (idx_q == '0);
    assign res_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    mlp_valid_delay #(
        .LAT(LAT)
    ) u_dly (
        .clk  (clk),
        .clr  (rst),
        .vin  (feed),
        .vout (acc_en)
    );

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer across three parameter sets.
module tb_mlp_layer_sequencer;

    typedef struct packed {
        logic [31:0] idx;
        logic [1:0]  neuron;
        logic        clr;
        logic        en;
        logic        rv;
        logic        busy;
        logic        done;
    } obs_t;

    logic clk = 0;
    logic rst = 1;
    logic start_a = 0, start_b = 0, start_c = 0;
    logic rdy_a = 1, rdy_b = 1, rdy_c = 1;

    logic [31:0] idx_a, idx_b, idx_c;
    logic [1:0]  n_a, n_b;
    logic [0:0]  n_c;
    logic clr_a, en_a, rv_a, busy_a, done_a;
    logic clr_b, en_b, rv_b, busy_b, done_b;
    logic clr_c, en_c, rv_c, busy_c, done_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mlp_layer_sequencer #(.WIDTH(3), .NEURONS(4), .LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .idx(idx_a), .neuron(n_a),
        .acc_clr(clr_a), .acc_en(en_a), .res_valid(rv_a), .res_ready(rdy_a),
        .busy(busy_a), .done(done_a));

    mlp_layer_sequencer #(.WIDTH(3), .NEURONS(4), .LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .idx(idx_b), .neuron(n_b),
        .acc_clr(clr_b), .acc_en(en_b), .res_valid(rv_b), .res_ready(rdy_b),
        .busy(busy_b), .done(done_b));

    mlp_layer_sequencer #(.WIDTH(0), .NEURONS(1), .LAT(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .idx(idx_c), .neuron(n_c),
        .acc_clr(clr_c), .acc_en(en_c), .res_valid(rv_c), .res_ready(rdy_c),
        .busy(busy_c), .done(done_c));

    function automatic obs_t obs_a();
        return '{idx_a, n_a, clr_a, en_a, rv_a, busy_a, done_a};
    endfunction
    function automatic obs_t obs_b();
        return '{idx_b, n_b, clr_b, en_b, rv_b, busy_b, done_b};
    endfunction
    function automatic obs_t obs_c();
        return '{idx_c, 2'(n_c), clr_c, en_c, rv_c, busy_c, done_c};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("idx=%0d n=%0d clr=%b en=%b rv=%b busy=%b done=%b",
                         o.idx, o.neuron, o.clr, o.en, o.rv, o.busy, o.done);
    endfunction

    // Expected trace with res_ready high and start sampled at the end of cycle 0.
    // Each neuron occupies P = w+1+l+1 cycles: FEED w+1, DRAIN l, HOLD 1.
    function automatic obs_t model(input int w, input int n, input int l, input int c);
        obs_t e;
        int p, k, o;
        e = '0;
        p = w + l + 2;
        if (c >= 1 && c <= n * p) begin
            k = (c - 1) / p;
            o = (c - 1) % p;
            e.neuron = 2'(k);
            e.busy   = 1'b1;
            if (o <= w) begin
                e.idx = 32'(o);
                e.clr = (o == 0);
            end
            e.en = (o >= l) && (o <= w + l);
            e.rv = (o == w + l + 1);
        end else if (c == n * p + 1) begin
            e.neuron = 2'(n - 1);
            e.busy   = 1'b1;
            e.done   = 1'b1;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1;
        repeat (3) step();
        o = obs_a();
        checks++;
        if (o !== '0) begin failures++; $display("FAIL reset_a got %s exp all zero", fmt(o)); end
        o = obs_b();
        checks++;
        if (o !== '0) begin failures++; $display("FAIL reset_b got %s exp all zero", fmt(o)); end
        o = obs_c();
        checks++;
        if (o !== '0) begin failures++; $display("FAIL reset_c got %s exp all zero", fmt(o)); end
        rst = 0;
        step();
    endtask

    // Full layer on dut_a; optional spurious starts at FEED, HOLD and DONE cycles.
    task automatic run_a(input string nm, input bit spurious);
        obs_t o, e;
        for (int c = 0; c <= 28; c++) begin
            start_a = (c == 0) || (spurious && (c == 3 || c == 6 || c == 13 || c == 25));
            o = obs_a();
            e = model(3, 4, 1, c);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s c=%0d got %s exp %s", nm, c, fmt(o), fmt(e));
            end
            step();
        end
        start_a = 0;
    endtask

    task automatic test_layer();
        run_a("layer", 1'b0);
    endtask

    task automatic test_backpressure();
        obs_t o, e;
        for (int c = 0; c <= 32; c++) begin
            start_a = (c == 0);
            rdy_a   = !(c >= 6 && c <= 9);
            o = obs_a();
            if (c <= 5)       e = model(3, 4, 1, c);
            else if (c <= 10) e = model(3, 4, 1, 6);
            else              e = model(3, 4, 1, c - 4);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL backpressure c=%0d got %s exp %s", c, fmt(o), fmt(e));
            end
            step();
        end
        rdy_a = 1;
        start_a = 0;
    endtask

    task automatic test_lat3();
        obs_t o, e;
        int en_cnt = 0;
        int first_en = -1;
        for (int c = 0; c <= 42; c++) begin
            start_b = (c == 0);
            o = obs_b();
            e = model(3, 4, 3, c);
            if (o.en) begin
                en_cnt++;
                if (first_en < 0) first_en = c;
            end
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lat3 c=%0d got %s exp %s", c, fmt(o), fmt(e));
            end
            step();
        end
        start_b = 0;
        checks++;
        if (en_cnt !== 16) begin failures++; $display("FAIL lat3_en_count got %0d exp 16", en_cnt); end
        checks++;
        if (first_en !== 4) begin failures++; $display("FAIL lat3_first_en got %0d exp 4", first_en); end
    endtask

    task automatic test_reset_mid();
        obs_t o, e;
        for (int c = 0; c <= 14; c++) begin
            start_a = (c == 0);
            o = obs_a();
            e = model(3, 4, 1, c);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pre_reset c=%0d got %s exp %s", c, fmt(o), fmt(e));
            end
            if (c == 14) rst = 1;
            step();
        end
        start_a = 0;
        o = obs_a();
        checks++;
        if (o !== '0) begin failures++; $display("FAIL mid_reset got %s exp all zero", fmt(o)); end
        rst = 0;
        step();
        o = obs_a();
        checks++;
        if (o !== '0) begin failures++; $display("FAIL post_reset_idle got %s exp all zero", fmt(o)); end
        run_a("after_reset", 1'b0);
    endtask

    task automatic test_spurious_start();
        run_a("spurious", 1'b1);
    endtask

    task automatic test_single();
        obs_t o, e;
        for (int c = 0; c <= 7; c++) begin
            start_c = (c == 0);
            o = obs_c();
            e = model(0, 1, 1, c);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single c=%0d got %s exp %s", c, fmt(o), fmt(e));
            end
            step();
        end
        start_c = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_layer();
        test_backpressure();
        test_lat3();
        test_reset_mid();
        test_spurious_start();
        test_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
